// File: rtl/teclado_pin.sv
// teclado_pin: 4x4 keypad PIN entry and access-request transmitter; define TECLA_BORRAR_EN to make key C a clear key
module teclado_pin #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEB_CYCLES   = 20000,
   parameter int GAP          = 2,
   parameter int RESP_TIMEOUT = 16
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [3:0] FILA,
   output logic [3:0] COL,
   input  logic       ACCESO_ACEPTADO,
   input  logic       ACCESO_DENEGADO,
   output logic       SOLICITUD_ACCESO,
   output logic [3:0] DIGITO,
   output logic       DIGITO_STB,
   output logic [2:0] CUENTA,
   output logic       OCUPADO,
   output logic       RES_OK,
   output logic       RES_ERR,
   output logic       RES_TO
);
   localparam int SW = $clog2(SCAN_DIV + 1);
   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam int GW = $clog2(GAP + 2);
   localparam int TW = $clog2(RESP_TIMEOUT + 1);

   typedef enum logic [2:0] {ESCANEO, REBOTE_PRES, SOLTAR, TX_SOL, TX_GAP, TX_DIG, ESPERA_RES} state_t;

   state_t        state_q, state_d;
   logic [3:0]    fila_m_q, fila_s_q;
   logic [3:0]    col_q, col_d, cap_q, cap_d, digito_q, digito_d;
   logic [SW-1:0] div_q, div_d;
   logic [DW-1:0] deb_q, deb_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [1:0]    idx_q, idx_d, fil_idx, col_idx;
   logic [2:0]    cuenta_q, cuenta_d;
   logic [3:0]    dig_buf_q [4];
   logic [3:0]    dig_buf_d [4];
   logic          ok_q, ok_d, err_q, err_d, to_q, to_d, una_fila;
   logic [3:0]    key;

   assign fil_idx  = cap_q[3] ? 2'd3 : cap_q[2] ? 2'd2 : cap_q[1] ? 2'd1 : 2'd0;
   assign col_idx  = col_q[3] ? 2'd3 : col_q[2] ? 2'd2 : col_q[1] ? 2'd1 : 2'd0;
   assign key      = {fil_idx, col_idx};
   assign una_fila = (fila_s_q != 4'd0) && ((fila_s_q & (fila_s_q - 4'd1)) == 4'd0);

   assign OCUPADO          = state_q inside {TX_SOL, TX_GAP, TX_DIG, ESPERA_RES};
   assign COL              = OCUPADO ? 4'd0 : col_q;
   assign SOLICITUD_ACCESO = state_q == TX_SOL;
   assign DIGITO_STB       = state_q == TX_DIG;
   assign DIGITO           = DIGITO_STB ? dig_buf_q[idx_q] : digito_q;
   assign CUENTA           = cuenta_q;
   assign RES_OK           = ok_q;
   assign RES_ERR          = err_q;
   assign RES_TO           = to_q;

   // scan, debounce, digit buffering, handshake sequencing and verdict capture
   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      cap_d     = cap_q;
      div_d     = div_q;
      deb_d     = deb_q;
      gap_d     = gap_q;
      tmo_d     = tmo_q;
      idx_d     = idx_q;
      cuenta_d  = cuenta_q;
      dig_buf_d = dig_buf_q;
      digito_d  = digito_q;
      ok_d      = ok_q;
      err_d     = err_q;
      to_d      = to_q;
      case (state_q)
         ESCANEO: begin
            if (una_fila) begin
               cap_d   = fila_s_q;
               deb_d   = '0;
               state_d = REBOTE_PRES;
            end else if (div_q == SW'(SCAN_DIV - 1)) begin
               div_d = '0;
               col_d = {col_q[2:0], col_q[3]};
            end else div_d = div_q + 1'b1;
         end
         REBOTE_PRES: begin
            if (fila_s_q != cap_q) state_d = ESCANEO;
            else if (deb_q == DW'(DEB_CYCLES - 1)) begin
               deb_d   = '0;
               state_d = SOLTAR;
`ifdef TECLA_BORRAR_EN
               if (key == 4'hC) cuenta_d = 3'd0;
               else begin
                  dig_buf_d[cuenta_q[1:0]] = key;
                  cuenta_d = cuenta_q + 3'd1;
               end
`else
               dig_buf_d[cuenta_q[1:0]] = key;
               cuenta_d = cuenta_q + 3'd1;
`endif
            end else deb_d = deb_q + 1'b1;
         end
         SOLTAR: begin
            if (fila_s_q != 4'd0) deb_d = '0;
            else if (deb_q == DW'(DEB_CYCLES - 1)) begin
               deb_d   = '0;
               state_d = (cuenta_q == 3'd4) ? TX_SOL : ESCANEO;
               if (cuenta_q == 3'd4) begin
                  ok_d  = 1'b0;
                  err_d = 1'b0;
                  to_d  = 1'b0;
               end
            end else deb_d = deb_q + 1'b1;
         end
         TX_SOL: begin
            gap_d   = '0;
            idx_d   = 2'd0;
            state_d = (GAP == 0) ? TX_DIG : TX_GAP;
         end
         TX_GAP: begin
            if (gap_q == GW'(GAP - 1)) begin
               gap_d   = '0;
               state_d = TX_DIG;
            end else gap_d = gap_q + 1'b1;
         end
         TX_DIG: begin
            digito_d = dig_buf_q[idx_q];
            gap_d    = '0;
            tmo_d    = '0;
            idx_d    = idx_q + 2'd1;
            state_d  = (idx_q == 2'd3) ? ESPERA_RES : (GAP == 0) ? TX_DIG : TX_GAP;
         end
         ESPERA_RES: begin
            if (ACCESO_DENEGADO || ACCESO_ACEPTADO || tmo_q == TW'(RESP_TIMEOUT - 1)) begin
               ok_d     = ACCESO_ACEPTADO && !ACCESO_DENEGADO;
               err_d    = !ok_d;
               to_d     = !ACCESO_DENEGADO && !ACCESO_ACEPTADO;
               cuenta_d = 3'd0;
               state_d  = ESCANEO;
            end else tmo_d = tmo_q + 1'b1;
         end
         default: state_d = ESCANEO;
      endcase
   end

   // two-flop synchroniser for the asynchronous row lines
   always_ff @(posedge CLK) begin
      fila_m_q <= FILA;
      fila_s_q <= fila_m_q;
   end

   // state registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= ESCANEO;
         col_q     <= 4'b0001;
         cap_q     <= '0;
         div_q     <= '0;
         deb_q     <= '0;
         gap_q     <= '0;
         tmo_q     <= '0;
         idx_q     <= '0;
         cuenta_q  <= '0;
         dig_buf_q <= '{default: '0};
         digito_q  <= '0;
         ok_q      <= 1'b0;
         err_q     <= 1'b0;
         to_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         cap_q     <= cap_d;
         div_q     <= div_d;
         deb_q     <= deb_d;
         gap_q     <= gap_d;
         tmo_q     <= tmo_d;
         idx_q     <= idx_d;
         cuenta_q  <= cuenta_d;
         dig_buf_q <= dig_buf_d;
         digito_q  <= digito_d;
         ok_q      <= ok_d;
         err_q     <= err_d;
         to_q      <= to_d;
      end
   end
endmodule

// File: tb/tb_teclado_pin.sv
// tb_teclado_pin: keypad-model bench for teclado_pin with a digit scoreboard
module tb_teclado_pin;
   localparam int SCAN_DIV = 4, DEB_CYCLES = 8, GAP = 2, RESP_TIMEOUT = 16;

   logic clk = 1'b0, rst = 1'b1, acc = 1'b0, den = 1'b0;
   logic [3:0] fila, col, digito;
   logic sol, stb, ocupado, res_ok, res_err, res_to;
   logic [2:0] cuenta;
   logic [15:0] pressed = '0;
   logic [3:0] last_dig = '0;
   logic [3:0] exp_q [$];
   int checks = 0, errors = 0, cyc = 0, sol_cyc = 0, last_stb_cyc = 0;
   int sol_cnt = 0, stb_cnt = 0, stb_in_att = 0;

   teclado_pin #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB_CYCLES), .GAP(GAP), .RESP_TIMEOUT(RESP_TIMEOUT)) dut (
      .CLK(clk), .RESET(rst), .FILA(fila), .COL(col),
      .ACCESO_ACEPTADO(acc), .ACCESO_DENEGADO(den),
      .SOLICITUD_ACCESO(sol), .DIGITO(digito), .DIGITO_STB(stb),
      .CUENTA(cuenta), .OCUPADO(ocupado), .RES_OK(res_ok), .RES_ERR(res_err), .RES_TO(res_to)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // a row reads high when a pressed key sits in a driven column
   always_comb begin
      fila = '0;
      for (int r = 0; r < 4; r++) fila[r] = |(pressed[r*4 +: 4] & col);
   end

   // handshake monitor: request conditions, strobe timing and scoreboard pops
   always @(negedge clk) begin
      if (sol) begin
         sol_cnt++;
         sol_cyc = cyc;
         stb_in_att = 0;
         checks++;
         if ({res_ok, res_err, res_to, stb, ocupado, col} !== 9'b000010000) begin
            errors++;
            $display("FAIL sol_cycle got ok/err/to/stb/ocup/col=%b exp=000010000", {res_ok, res_err, res_to, stb, ocupado, col});
         end
      end
      if (stb) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stb_unexpected got digit=%h exp=no strobe", digito);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if (digito !== e) begin
               errors++;
               $display("FAIL stb_digit got=%h exp=%h", digito, e);
            end
         end
         checks++;
         if (cyc - sol_cyc !== (GAP + 1) * (stb_in_att + 1)) begin
            errors++;
            $display("FAIL stb_timing got=+%0d exp=+%0d", cyc - sol_cyc, (GAP + 1) * (stb_in_att + 1));
         end
         checks++;
         if (ocupado !== 1'b1 || sol !== 1'b0) begin
            errors++;
            $display("FAIL stb_busy got ocup=%b sol=%b exp ocup=1 sol=0", ocupado, sol);
         end
         stb_in_att++;
         stb_cnt++;
         last_stb_cyc = cyc;
         last_dig = digito;
      end else if (stb_in_att > 0 && ocupado) begin
         checks++;
         if (digito !== last_dig) begin
            errors++;
            $display("FAIL digito_hold got=%h exp=%h", digito, last_dig);
         end
      end
   end

   task automatic press_key(input int code, input logic [2:0] exp_cnt);
      logic [2:0] c0;
      int n;
      c0 = cuenta;
      n = 0;
      pressed[code] = 1'b1;
      while (cuenta === c0 && n < 80) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (cuenta !== exp_cnt) begin
         errors++;
         $display("FAIL press_%0h cuenta got=%0d exp=%0d", code, cuenta, exp_cnt);
      end
      repeat (4) @(negedge clk);
      pressed[code] = 1'b0;
      repeat (14) @(negedge clk);
   endtask

   task automatic await_tx(input int s0, input int p0);
      int n;
      n = 0;
      while (stb_cnt < s0 + 4 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (stb_cnt !== s0 + 4) begin
         errors++;
         $display("FAIL tx_strobes got=%0d exp=4", stb_cnt - s0);
      end
      checks++;
      if (sol_cnt !== p0 + 1) begin
         errors++;
         $display("FAIL tx_requests got=%0d exp=1", sol_cnt - p0);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (col !== 4'b0001) begin
         errors++;
         $display("FAIL reset_col got=%b exp=0001", col);
      end
      checks++;
      if ({sol, digito, stb, cuenta, ocupado, res_ok, res_err, res_to} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=0", {sol, digito, stb, cuenta, ocupado, res_ok, res_err, res_to});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_clean_pin();
      logic [3:0] pin [4] = '{4'h6, 4'h9, 4'h6, 4'h9};
      int s0, p0;
      s0 = stb_cnt;
      p0 = sol_cnt;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(pin[i]);
         press_key(pin[i], 3'(i + 1));
      end
      await_tx(s0, p0);
   endtask

   task automatic test_denied();
      logic [3:0] c0;
      while (cyc < last_stb_cyc + 4) @(negedge clk);
      den = 1'b1;
      @(negedge clk);
      den = 1'b0;
      checks++;
      if ({res_ok, res_err, res_to, cuenta, ocupado} !== 7'b0100000) begin
         errors++;
         $display("FAIL denied got ok/err/to/cuenta/ocup=%b exp=0100000", {res_ok, res_err, res_to, cuenta, ocupado});
      end
      c0 = col;
      repeat (SCAN_DIV + 1) @(negedge clk);
      checks++;
      if (col === c0 || col === 4'd0) begin
         errors++;
         $display("FAIL scan_resume got col=%b exp rotated from %b", col, c0);
      end
   endtask

   task automatic test_bounce();
      int n;
      n = 0;
      while (col !== 4'b0100 && n < 40) begin
         @(negedge clk);
         n++;
      end
      exp_q.push_back(4'h6);
      for (int i = 0; i < 5; i++) begin
         pressed[6] = ~pressed[6];
         @(negedge clk);
      end
      pressed[6] = 1'b1;
      n = 0;
      while (cuenta === 3'd0 && n < 80) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (cuenta !== 3'd1) begin
         errors++;
         $display("FAIL bounce_accept cuenta got=%0d exp=1", cuenta);
      end
      repeat (40) @(negedge clk);
      checks++;
      if (cuenta !== 3'd1) begin
         errors++;
         $display("FAIL bounce_single cuenta got=%0d exp=1", cuenta);
      end
      pressed[6] = 1'b0;
      repeat (14) @(negedge clk);
   endtask

   task automatic test_accept();
      int s0, p0;
      s0 = stb_cnt;
      p0 = sol_cnt;
      for (int i = 1; i < 4; i++) begin
         exp_q.push_back(4'(i));
         press_key(i, 3'(i + 1));
      end
      await_tx(s0, p0);
      while (cyc < last_stb_cyc + 4) @(negedge clk);
      acc = 1'b1;
      @(negedge clk);
      acc = 1'b0;
      checks++;
      if ({res_ok, res_err, res_to, cuenta, ocupado} !== 7'b1000000) begin
         errors++;
         $display("FAIL accepted got ok/err/to/cuenta/ocup=%b exp=1000000", {res_ok, res_err, res_to, cuenta, ocupado});
      end
   endtask

   task automatic test_timeout();
      int s0, p0;
      s0 = stb_cnt;
      p0 = sol_cnt;
      for (int i = 1; i < 5; i++) begin
         exp_q.push_back(4'(i));
         press_key(i, 3'(i));
      end
      await_tx(s0, p0);
      while (cyc < last_stb_cyc + 2) @(negedge clk);
      pressed[5] = 1'b1;
      while (cyc < last_stb_cyc + 10) @(negedge clk);
      pressed[5] = 1'b0;
      while (cyc < last_stb_cyc + 16) @(negedge clk);
      checks++;
      if (ocupado !== 1'b1 || res_to !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early got ocup=%b to=%b exp ocup=1 to=0", ocupado, res_to);
      end
      @(negedge clk);
      checks++;
      if ({res_ok, res_err, res_to, cuenta, ocupado} !== 7'b0110000) begin
         errors++;
         $display("FAIL timeout got ok/err/to/cuenta/ocup=%b exp=0110000", {res_ok, res_err, res_to, cuenta, ocupado});
      end
      repeat (30) @(negedge clk);
      checks++;
      if (cuenta !== 3'd0) begin
         errors++;
         $display("FAIL busy_key_lost cuenta got=%0d exp=0", cuenta);
      end
   endtask

   task automatic test_two_rows();
      pressed[4] = 1'b1;
      pressed[8] = 1'b1;
      repeat (60) @(negedge clk);
      checks++;
      if (cuenta !== 3'd0) begin
         errors++;
         $display("FAIL two_rows cuenta got=%0d exp=0", cuenta);
      end
      pressed[4] = 1'b0;
      pressed[8] = 1'b0;
      repeat (14) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [3:0] pin [4] = '{4'h7, 4'h8, 4'hA, 4'hB};
      int s0, p0, n;
      s0 = stb_cnt;
      p0 = sol_cnt;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(pin[i]);
         press_key(pin[i], 3'(i + 1));
      end
      n = 0;
      while (stb_cnt < s0 + 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({col, sol, digito, stb, cuenta, ocupado, res_ok, res_err, res_to} !== 17'b00010000000000000) begin
         errors++;
         $display("FAIL reset_mid got=%b exp=00010000000000000", {col, sol, digito, stb, cuenta, ocupado, res_ok, res_err, res_to});
      end
      rst = 1'b0;
      exp_q.delete();
      repeat (40) @(negedge clk);
      checks++;
      if (stb_cnt !== s0 + 2 || sol_cnt !== p0 + 1) begin
         errors++;
         $display("FAIL reset_mid_pulses got stb=%0d sol=%0d exp stb=2 sol=1", stb_cnt - s0, sol_cnt - p0);
      end
   endtask

   task automatic test_key_c();
      int p0;
      p0 = sol_cnt;
`ifdef TECLA_BORRAR_EN
      press_key(1, 3'd1);
      press_key(2, 3'd2);
      press_key(12, 3'd0);
`else
      press_key(12, 3'd1);
`endif
      repeat (30) @(negedge clk);
      checks++;
      if (sol_cnt !== p0) begin
         errors++;
         $display("FAIL key_c_no_tx got=%0d requests exp=0", sol_cnt - p0);
      end
   endtask

   initial begin
      test_reset();
      test_clean_pin();
      test_denied();
      test_bounce();
      test_accept();
      test_timeout();
      test_two_rows();
      test_reset_mid();
      test_key_c();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
